// File: rtl/cpu_pkg.sv
// cpu_pkg: encodings shared by decode, the ID/EX stage and the ALU.
//
// Contents:
//   ALU_*      5-bit ALU operation codes driven on ALU_operation
//   OP1_*      operand-1 select (register rs1 or instruction pc)
//   OP2_*      operand-2 select (register rs2 or immediate)
//   fwd_sel_e  per-source forwarding select (register file, MEM, WB)
//   src_match  true when a used, non-x0 source reads a destination that
//              is being written
package cpu_pkg;

   // ALU operation codes
   localparam logic [4:0] ALU_ADD  = 5'b00000;
   localparam logic [4:0] ALU_SUB  = 5'b00001;
   localparam logic [4:0] ALU_SLL  = 5'b00010;
   localparam logic [4:0] ALU_XOR  = 5'b00100;
   localparam logic [4:0] ALU_SRL  = 5'b00101;
   localparam logic [4:0] ALU_OR   = 5'b00110;
   localparam logic [4:0] ALU_AND  = 5'b00111;
   localparam logic [4:0] ALU_SRA  = 5'b01101;
   localparam logic [4:0] ALU_SLT  = 5'b10110;
   localparam logic [4:0] ALU_SLTU = 5'b10111;

   // Operand select encodings
   localparam logic OP1_RS1 = 1'b0;
   localparam logic OP1_PC  = 1'b1;
   localparam logic OP2_RS2 = 1'b0;
   localparam logic OP2_IMM = 1'b1;

   // Forwarding source for one EX operand
   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,
      FWD_MEM = 2'b01,
      FWD_WB  = 2'b10
   } fwd_sel_e;

   // x0 is hard-wired zero, so it never matches any destination.
   function automatic logic src_match(input logic       used,
                                      input logic [4:0] src,
                                      input logic       we,
                                      input logic [4:0] dst);
      return used && (src != 5'd0) && we && (src == dst);
   endfunction

endpackage

// File: rtl/id_ex_stage_fwd_unit.sv
// fwd_unit: combinational forwarding-select and decode-hazard logic for
// the ID/EX stage.
//
// Build option: ID_EX_FORWARD_EN
//   defined   - EX sources forward from MEM (priority) or WB; decode only
//               stalls on a load-use dependency against the EX instruction.
//   undefined - both selects stay on the register file; decode stalls
//               while any used source matches a pending write in EX, MEM
//               or WB.
//
// Ports:
//   ex_rs1/ex_rs2, ex_rs1_used/ex_rs2_used  sources of the instruction in EX
//   ex_valid, ex_rd, ex_reg_write, ex_mem_read  EX destination/control
//   mem_rd, mem_reg_write, wb_rd, wb_reg_write  downstream destinations
//   id_valid, id_rs1/id_rs2, id_rs1_used/id_rs2_used  decode sources
//   flush      kills decode; suppresses the hazard
//   fwd_sel1, fwd_sel2  forwarding select per EX source
//   hazard     decode must hold this cycle
module fwd_unit
   import cpu_pkg::*;
(
   input  logic       ex_valid,
   input  logic [4:0] ex_rd,
   input  logic       ex_reg_write,
   input  logic       ex_mem_read,
   input  logic [4:0] ex_rs1,
   input  logic [4:0] ex_rs2,
   input  logic       ex_rs1_used,
   input  logic       ex_rs2_used,
   input  logic [4:0] mem_rd,
   input  logic       mem_reg_write,
   input  logic [4:0] wb_rd,
   input  logic       wb_reg_write,
   input  logic       id_valid,
   input  logic [4:0] id_rs1,
   input  logic [4:0] id_rs2,
   input  logic       id_rs1_used,
   input  logic       id_rs2_used,
   input  logic       flush,
   output fwd_sel_e   fwd_sel1,
   output fwd_sel_e   fwd_sel2,
   output logic       hazard
);

`ifdef ID_EX_FORWARD_EN

   always_comb begin : fwd_select
      fwd_sel1 = FWD_RF;
      fwd_sel2 = FWD_RF;
      // MEM holds the younger result, so it wins over WB.
      if (src_match(ex_rs1_used, ex_rs1, mem_reg_write, mem_rd)) begin
         fwd_sel1 = FWD_MEM;
      end else if (src_match(ex_rs1_used, ex_rs1, wb_reg_write, wb_rd)) begin
         fwd_sel1 = FWD_WB;
      end
      if (src_match(ex_rs2_used, ex_rs2, mem_reg_write, mem_rd)) begin
         fwd_sel2 = FWD_MEM;
      end else if (src_match(ex_rs2_used, ex_rs2, wb_reg_write, wb_rd)) begin
         fwd_sel2 = FWD_WB;
      end
   end

   // Load data is only available from WB, one cycle too late for a consumer
   // directly behind the load.
   always_comb begin : load_use
      hazard = id_valid && ex_valid && ex_mem_read && !flush &&
               (src_match(id_rs1_used, id_rs1, ex_reg_write, ex_rd) ||
                src_match(id_rs2_used, id_rs2, ex_reg_write, ex_rd));
   end

`else

   logic rs1_pending;
   logic rs2_pending;
   logic unused_fwd_inputs;

   // Without bypassing, the register file only returns a new value once the
   // writer has left WB, so every in-flight writer blocks decode.
   always_comb begin : pending_writes
      rs1_pending = src_match(id_rs1_used, id_rs1, ex_reg_write,  ex_rd)  ||
                    src_match(id_rs1_used, id_rs1, mem_reg_write, mem_rd) ||
                    src_match(id_rs1_used, id_rs1, wb_reg_write,  wb_rd);
      rs2_pending = src_match(id_rs2_used, id_rs2, ex_reg_write,  ex_rd)  ||
                    src_match(id_rs2_used, id_rs2, mem_reg_write, mem_rd) ||
                    src_match(id_rs2_used, id_rs2, wb_reg_write,  wb_rd);
   end

   always_comb begin : no_forward
      fwd_sel1 = FWD_RF;
      fwd_sel2 = FWD_RF;
      hazard   = id_valid && !flush && (rs1_pending || rs2_pending);
   end

   assign unused_fwd_inputs = ^{ex_valid, ex_mem_read, ex_rs1, ex_rs2,
                                ex_rs1_used, ex_rs2_used};

`endif

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with operand forwarding/selection,
// decode hazard detection and a saturating stall-cycle counter.
//
// Build option: ID_EX_FORWARD_EN (see fwd_unit). Undefined by default,
// which removes forwarding and stalls decode on any pending writer.
//
// Parameters: XLEN datapath width, CNT_W stall counter width.
// Ports:
//   clk, rst           rising-edge clock, synchronous active-high reset
//   id_*               decoded instruction fields and control bits
//   flush              taken branch/jump in EX; decode becomes a bubble
//   mem_*/wb_*         downstream destination, write enable and result
//   Operand1/Operand2  ALU operands (combinational from forwarding)
//   ALU_operation      ALU op of the instruction in EX
//   ex_*               EX sideband; ex_store_data is forwarded rs2
//   stall_id           hold PC and IF/ID this cycle
//   stall_count        number of cycles stall_id was high, saturating
module id_ex_stage
   import cpu_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid,
   input  logic [XLEN-1:0]  id_pc,
   input  logic [XLEN-1:0]  id_rs1_data,
   input  logic [XLEN-1:0]  id_rs2_data,
   input  logic [XLEN-1:0]  id_imm,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic [4:0]       id_rd,
   input  logic             id_rs1_used,
   input  logic             id_rs2_used,
   input  logic [4:0]       id_alu_op,
   input  logic             id_op1_sel,
   input  logic             id_op2_sel,
   input  logic             id_reg_write,
   input  logic             id_mem_read,
   input  logic             id_mem_write,
   input  logic             flush,
   input  logic [4:0]       mem_rd,
   input  logic             mem_reg_write,
   input  logic [XLEN-1:0]  mem_result,
   input  logic [4:0]       wb_rd,
   input  logic             wb_reg_write,
   input  logic [XLEN-1:0]  wb_result,
   output logic [XLEN-1:0]  Operand1,
   output logic [XLEN-1:0]  Operand2,
   output logic [4:0]       ALU_operation,
   output logic             ex_valid,
   output logic [4:0]       ex_rd,
   output logic             ex_reg_write,
   output logic             ex_mem_read,
   output logic             ex_mem_write,
   output logic [XLEN-1:0]  ex_pc,
   output logic [XLEN-1:0]  ex_store_data,
   output logic             stall_id,
   output logic [CNT_W-1:0] stall_count
);

   // ID/EX register
   logic             ex_valid_q,     ex_valid_d;
   logic [4:0]       ex_rd_q,        ex_rd_d;
   logic [4:0]       ex_rs1_q,       ex_rs1_d;
   logic [4:0]       ex_rs2_q,       ex_rs2_d;
   logic             ex_rs1_used_q,  ex_rs1_used_d;
   logic             ex_rs2_used_q,  ex_rs2_used_d;
   logic             ex_reg_write_q, ex_reg_write_d;
   logic             ex_mem_read_q,  ex_mem_read_d;
   logic             ex_mem_write_q, ex_mem_write_d;
   logic [4:0]       ex_alu_op_q,    ex_alu_op_d;
   logic             ex_op1_sel_q,   ex_op1_sel_d;
   logic             ex_op2_sel_q,   ex_op2_sel_d;
   logic [XLEN-1:0]  ex_pc_q,        ex_pc_d;
   logic [XLEN-1:0]  ex_rs1_data_q,  ex_rs1_data_d;
   logic [XLEN-1:0]  ex_rs2_data_q,  ex_rs2_data_d;
   logic [XLEN-1:0]  ex_imm_q,       ex_imm_d;
   logic [CNT_W-1:0] stall_count_q,  stall_count_d;

   fwd_sel_e        fwd_sel1;
   fwd_sel_e        fwd_sel2;
   logic            hazard;
   logic [XLEN-1:0] rs1_fwd;
   logic [XLEN-1:0] rs2_fwd;

   fwd_unit u_fwd_unit (
      .ex_valid      (ex_valid_q),
      .ex_rd         (ex_rd_q),
      .ex_reg_write  (ex_reg_write_q),
      .ex_mem_read   (ex_mem_read_q),
      .ex_rs1        (ex_rs1_q),
      .ex_rs2        (ex_rs2_q),
      .ex_rs1_used   (ex_rs1_used_q),
      .ex_rs2_used   (ex_rs2_used_q),
      .mem_rd        (mem_rd),
      .mem_reg_write (mem_reg_write),
      .wb_rd         (wb_rd),
      .wb_reg_write  (wb_reg_write),
      .id_valid      (id_valid),
      .id_rs1        (id_rs1),
      .id_rs2        (id_rs2),
      .id_rs1_used   (id_rs1_used),
      .id_rs2_used   (id_rs2_used),
      .flush         (flush),
      .fwd_sel1      (fwd_sel1),
      .fwd_sel2      (fwd_sel2),
      .hazard        (hazard)
   );

   // Reset forces every output to zero, including the hazard output.
   assign stall_id = hazard & ~rst;

   // A bubble clears the whole register so a killed instruction leaves
   // nothing behind in EX.
   always_comb begin : idex_next
      ex_valid_d     = 1'b0;
      ex_rd_d        = 5'd0;
      ex_rs1_d       = 5'd0;
      ex_rs2_d       = 5'd0;
      ex_rs1_used_d  = 1'b0;
      ex_rs2_used_d  = 1'b0;
      ex_reg_write_d = 1'b0;
      ex_mem_read_d  = 1'b0;
      ex_mem_write_d = 1'b0;
      ex_alu_op_d    = ALU_ADD;
      ex_op1_sel_d   = OP1_RS1;
      ex_op2_sel_d   = OP2_RS2;
      ex_pc_d        = '0;
      ex_rs1_data_d  = '0;
      ex_rs2_data_d  = '0;
      ex_imm_d       = '0;
      if (!(flush || stall_id)) begin
         ex_valid_d     = id_valid;
         ex_rd_d        = id_rd;
         ex_rs1_d       = id_rs1;
         ex_rs2_d       = id_rs2;
         // Control bits of an invalid slot are dropped so it never writes,
         // accesses memory or takes part in forwarding.
         ex_rs1_used_d  = id_valid & id_rs1_used;
         ex_rs2_used_d  = id_valid & id_rs2_used;
         ex_reg_write_d = id_valid & id_reg_write;
         ex_mem_read_d  = id_valid & id_mem_read;
         ex_mem_write_d = id_valid & id_mem_write;
         ex_alu_op_d    = id_alu_op;
         ex_op1_sel_d   = id_op1_sel;
         ex_op2_sel_d   = id_op2_sel;
         ex_pc_d        = id_pc;
         ex_rs1_data_d  = id_rs1_data;
         ex_rs2_data_d  = id_rs2_data;
         ex_imm_d       = id_imm;
      end
   end

   always_comb begin : stall_counter_next
      stall_count_d = stall_count_q;
      if (stall_id && (stall_count_q != {CNT_W{1'b1}})) begin
         stall_count_d = stall_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clk) begin : idex_regs
      if (rst) begin
         ex_valid_q     <= 1'b0;
         ex_rd_q        <= 5'd0;
         ex_rs1_q       <= 5'd0;
         ex_rs2_q       <= 5'd0;
         ex_rs1_used_q  <= 1'b0;
         ex_rs2_used_q  <= 1'b0;
         ex_reg_write_q <= 1'b0;
         ex_mem_read_q  <= 1'b0;
         ex_mem_write_q <= 1'b0;
         ex_alu_op_q    <= ALU_ADD;
         ex_op1_sel_q   <= OP1_RS1;
         ex_op2_sel_q   <= OP2_RS2;
         ex_pc_q        <= '0;
         ex_rs1_data_q  <= '0;
         ex_rs2_data_q  <= '0;
         ex_imm_q       <= '0;
         stall_count_q  <= '0;
      end else begin
         ex_valid_q     <= ex_valid_d;
         ex_rd_q        <= ex_rd_d;
         ex_rs1_q       <= ex_rs1_d;
         ex_rs2_q       <= ex_rs2_d;
         ex_rs1_used_q  <= ex_rs1_used_d;
         ex_rs2_used_q  <= ex_rs2_used_d;
         ex_reg_write_q <= ex_reg_write_d;
         ex_mem_read_q  <= ex_mem_read_d;
         ex_mem_write_q <= ex_mem_write_d;
         ex_alu_op_q    <= ex_alu_op_d;
         ex_op1_sel_q   <= ex_op1_sel_d;
         ex_op2_sel_q   <= ex_op2_sel_d;
         ex_pc_q        <= ex_pc_d;
         ex_rs1_data_q  <= ex_rs1_data_d;
         ex_rs2_data_q  <= ex_rs2_data_d;
         ex_imm_q       <= ex_imm_d;
         stall_count_q  <= stall_count_d;
      end
   end

   // Operand paths are combinational from mem_*/wb_* so a result produced
   // this cycle reaches the ALU without waiting for the register file.
   always_comb begin : operand_select
      case (fwd_sel1)
         FWD_MEM: rs1_fwd = mem_result;
         FWD_WB:  rs1_fwd = wb_result;
         default: rs1_fwd = ex_rs1_data_q;
      endcase
      case (fwd_sel2)
         FWD_MEM: rs2_fwd = mem_result;
         FWD_WB:  rs2_fwd = wb_result;
         default: rs2_fwd = ex_rs2_data_q;
      endcase
      Operand1      = (ex_op1_sel_q == OP1_PC)  ? ex_pc_q  : rs1_fwd;
      Operand2      = (ex_op2_sel_q == OP2_IMM) ? ex_imm_q : rs2_fwd;
      ex_store_data = rs2_fwd;
   end

   assign ALU_operation = ex_alu_op_q;
   assign ex_valid      = ex_valid_q;
   assign ex_rd         = ex_rd_q;
   assign ex_reg_write  = ex_reg_write_q;
   assign ex_mem_read   = ex_mem_read_q;
   assign ex_mem_write  = ex_mem_write_q;
   assign ex_pc         = ex_pc_q;
   assign stall_count   = stall_count_q;

endmodule
